sa_load_sched: RTL and testbench
================================

Name: sa_load_sched

Overview:
- Controller that sequences one systolic-array job for the PE chain: weight load, chain flush, activation streaming with pop, result collection.
- Drives the array's head load port (o_load_vld/id/data), head pop_vld and left data input.
- Observes the array's returning pop_vld to detect job completion.
- Sits between the weight/activation stream sources and PE column 0.

Parameters:
- NUM_PE, 16, number of PEs in the load chain; also the flush wait in cycles (one register per PE).
- ID_WIDTH, 6, PE id width; must satisfy NUM_PE <= 2**ID_WIDTH.
- IN_DATA_WIDTH, 8, weight and activation width.
- WGT_DEPTH, 4, weight slots per PE.
- CNT_WIDTH, $clog2(WGT_DEPTH)+1, width of the weights-per-PE config field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- i_start  in  1  job start pulse
- i_cfg_pe_cnt  in  ID_WIDTH+1  PEs to load; legal range 1..NUM_PE
- i_cfg_wgt_cnt  in  CNT_WIDTH  weights per PE, equal to pops per job; legal range 1..WGT_DEPTH
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle completion pulse
- i_wgt_vld  in  1  weight stream valid
- i_wgt_data  in  IN_DATA_WIDTH  weight stream data
- o_wgt_rdy  out  1  weight stream ready
- i_act_vld  in  1  activation stream valid
- i_act_data  in  IN_DATA_WIDTH  activation stream data
- o_act_rdy  out  1  activation stream ready
- o_load_vld  out  1  load chain valid
- o_load_id  out  ID_WIDTH  target PE id
- o_load_data  out  IN_DATA_WIDTH  weight
- o_pop_vld  out  1  pop strobe to PE column 0
- o_left_data  out  IN_DATA_WIDTH  activation to PE column 0
- i_res_vld  in  1  pop_vld returning from the array tail

Behaviour:
- Reset (rst=0): all outputs 0, FSM in IDLE, all counters 0. Takes effect asynchronously, including mid-job. No residual pulse after release.
- States: IDLE, LOAD, FLUSH, RUN, WAIT, DONE.
- IDLE:
  - i_start with legal config: latch config, go to LOAD.
  - i_start with illegal config (zero or over range): go directly to DONE; no load or pop activity.
  - i_start in any state other than IDLE is ignored.
- o_busy = 1 in every state except IDLE. It is registered, so it rises the cycle after i_start is accepted.
- LOAD:
  - o_wgt_rdy = 1 (combinational, state==LOAD).
  - Each accepted beat is registered into o_load_vld=1, o_load_id=pe_ctr, o_load_data=i_wgt_data, one cycle after acceptance.
  - wgt_ctr wraps at cfg_wgt_cnt-1; pe_ctr increments on the wrap.
  - Acceptance with pe_ctr=cfg_pe_cnt-1 and wgt_ctr=cfg_wgt_cnt-1 moves to FLUSH.
  - o_load_vld = 0 on cycles with no acceptance. o_load_id/o_load_data hold their last value.
- FLUSH: count exactly NUM_PE cycles with o_wgt_rdy=0 and o_act_rdy=0, then go to RUN.
- RUN:
  - o_act_rdy = 1.
  - Each accepted beat gives a registered o_pop_vld=1 with o_left_data=i_act_data in the same cycle.
  - After cfg_wgt_cnt acceptances, go to WAIT. o_act_rdy is 0 from the cycle after the last acceptance.
- Result counter: counts i_res_vld in RUN and WAIT. i_res_vld in other states is ignored.
- WAIT: when the result count reaches cfg_wgt_cnt (including the cycle of the final i_res_vld), go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. Counters clear on IDLE entry.
- Stream stalls (vld low) in LOAD or RUN simply hold state. There is no timeout.
- Counters never exceed their configured terminal values; no wrap past cfg.

Decomposition:
- Shared package sa_pkg:
  - state enum sa_state_e.
  - localparams for default NUM_PE, WGT_DEPTH, ID_WIDTH and IN_DATA_WIDTH, shared with the PE.
- One sub-module: sa_wrap_cnt, a parameterised up-counter.
  - Inputs: clear, increment enable, terminal value.
  - Outputs: count, last flag.
  - Instantiated for wgt_ctr, pe_ctr, flush, pop and result counts.

Test Plan:
- cfg_pe_cnt=2, cfg_wgt_cnt=3, weights 0x11..0x16 with vld held high -> o_load_id 0,0,0,1,1,1 and matching o_load_data, each one cycle after acceptance. o_wgt_rdy falls after the 6th beat.
- Same job, NUM_PE=4 -> after the last load, o_act_rdy stays 0 for exactly 4 cycles, then rises.
- RUN with activations 0x01, (gap), 0x02, (gap, gap), 0x03 -> exactly 3 o_pop_vld pulses aligned with o_left_data 1,2,3. o_act_rdy is 0 after the 3rd acceptance.
- Three i_res_vld pulses, the first while still in RUN -> o_done high for one cycle, the cycle after the 3rd pulse. o_busy falls the next cycle.
- i_start asserted during LOAD -> no effect. i_start with cfg_wgt_cnt=0 -> o_done one cycle later, no o_load_vld or o_pop_vld.
- rst=0 mid-LOAD after 2 beats -> all outputs 0 immediately. After release, a new job restarts with o_load_id=0.

Source files
------------

// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
//   Shared definitions for the systolic-array slice: default geometry of the
//   PE chain and the load scheduler state encoding.
// ---------------------------------------------------------------------------
package sa_pkg;

  // Default array geometry, shared between the scheduler and the PE.
  localparam int SA_NUM_PE        = 16;
  localparam int SA_WGT_DEPTH     = 4;
  localparam int SA_ID_WIDTH      = 6;
  localparam int SA_IN_DATA_WIDTH = 8;

  // Job sequencing states of sa_load_sched.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } sa_state_e;

endpackage : sa_pkg

// File: rtl/sa_wrap_cnt.sv
// ---------------------------------------------------------------------------
// sa_wrap_cnt
//   Up-counter that wraps to zero after reaching a run-time terminal value.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous reset, active-low
//   i_clr   in   synchronous clear (wins over increment)
//   i_inc   in   increment enable
//   i_term  in   terminal value; the count after i_term is 0
//   o_cnt   out  current count
//   o_last  out  count equals i_term
// ---------------------------------------------------------------------------
module sa_wrap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  logic         at_term;

  assign at_term = (cnt_reg == i_term);

  always_comb begin
    cnt_next = cnt_reg;
    if (i_clr) begin
      cnt_next = '0;
    end else if (i_inc) begin
      cnt_next = at_term ? '0 : cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_cnt  = cnt_reg;
  assign o_last = at_term;

endmodule : sa_wrap_cnt

// File: rtl/sa_load_sched.sv
// ---------------------------------------------------------------------------
// sa_load_sched
//   Sequences one systolic-array job: loads cfg_pe_cnt x cfg_wgt_cnt weights
//   down the PE load chain, waits NUM_PE cycles for the chain to drain, then
//   streams cfg_wgt_cnt activations into PE column 0 together with pop
//   strobes, and finishes once as many pop strobes have come back from the
//   array tail.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous reset, active-low
//   i_start        in   job start pulse (only honoured in IDLE)
//   i_cfg_pe_cnt   in   PEs to load, legal 1..NUM_PE
//   i_cfg_wgt_cnt  in   weights per PE / pops per job, legal 1..WGT_DEPTH
//   o_busy         out  job in progress (registered)
//   o_done         out  one-cycle completion pulse
//   i_wgt_vld      in   weight stream valid
//   i_wgt_data     in   weight stream data
//   o_wgt_rdy      out  weight stream ready (LOAD)
//   i_act_vld      in   activation stream valid
//   i_act_data     in   activation stream data
//   o_act_rdy      out  activation stream ready (RUN)
//   o_load_vld     out  load chain valid, one cycle after weight acceptance
//   o_load_id      out  target PE id
//   o_load_data    out  weight
//   o_pop_vld      out  pop strobe to PE column 0
//   o_left_data    out  activation to PE column 0
//   i_res_vld      in   pop strobe returning from the array tail
// ---------------------------------------------------------------------------
module sa_load_sched
  import sa_pkg::*;
#(
  parameter int NUM_PE        = SA_NUM_PE,
  parameter int ID_WIDTH      = SA_ID_WIDTH,
  parameter int IN_DATA_WIDTH = SA_IN_DATA_WIDTH,
  parameter int WGT_DEPTH     = SA_WGT_DEPTH,
  parameter int CNT_WIDTH     = $clog2(WGT_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [ID_WIDTH:0]        i_cfg_pe_cnt,
  input  logic [CNT_WIDTH-1:0]     i_cfg_wgt_cnt,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_wgt_vld,
  input  logic [IN_DATA_WIDTH-1:0] i_wgt_data,
  output logic                     o_wgt_rdy,
  input  logic                     i_act_vld,
  input  logic [IN_DATA_WIDTH-1:0] i_act_data,
  output logic                     o_act_rdy,
  output logic                     o_load_vld,
  output logic [ID_WIDTH-1:0]      o_load_id,
  output logic [IN_DATA_WIDTH-1:0] o_load_data,
  output logic                     o_pop_vld,
  output logic [IN_DATA_WIDTH-1:0] o_left_data,
  input  logic                     i_res_vld
);

  localparam int                  FL_WIDTH = $clog2(NUM_PE) + 1;
  localparam logic [ID_WIDTH:0]   PE_MAX   = (ID_WIDTH + 1)'(NUM_PE);
  localparam logic [CNT_WIDTH-1:0] WGT_MAX = CNT_WIDTH'(WGT_DEPTH);
  localparam logic [FL_WIDTH-1:0] FL_TERM  = FL_WIDTH'(NUM_PE - 1);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  sa_state_e                state_reg;
  sa_state_e                state_next;
  logic                     busy_reg;
  logic [ID_WIDTH-1:0]      cfg_pe_m1_reg;   // cfg_pe_cnt - 1, the last PE id
  logic [CNT_WIDTH-1:0]     cfg_wgt_reg;
  logic                     load_vld_reg;
  logic [ID_WIDTH-1:0]      load_id_reg;
  logic [IN_DATA_WIDTH-1:0] load_data_reg;
  logic                     pop_vld_reg;
  logic [IN_DATA_WIDTH-1:0] left_data_reg;

  // -------------------------------------------------------------------------
  // Handshakes and decoded conditions
  // -------------------------------------------------------------------------
  logic                 start_acc;
  logic                 cfg_legal;
  logic                 wgt_acc;
  logic                 act_acc;
  logic                 cnt_clr;
  logic [CNT_WIDTH-1:0] wgt_term;
  logic                 res_window;
  logic                 res_inc;
  logic                 res_hit;

  assign start_acc = i_start && (state_reg == ST_IDLE);
  assign cfg_legal = (i_cfg_pe_cnt  != '0) && (i_cfg_pe_cnt  <= PE_MAX) &&
                     (i_cfg_wgt_cnt != '0) && (i_cfg_wgt_cnt <= WGT_MAX);

  assign o_wgt_rdy = (state_reg == ST_LOAD);
  assign o_act_rdy = (state_reg == ST_RUN);
  assign wgt_acc   = i_wgt_vld && o_wgt_rdy;
  assign act_acc   = i_act_vld && o_act_rdy;

  // Every counter is held at zero while idle, so each job starts clean.
  assign cnt_clr   = (state_reg == ST_IDLE);
  assign wgt_term  = cfg_wgt_reg - CNT_WIDTH'(1);

  // -------------------------------------------------------------------------
  // Counters
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] wgt_cnt;
  logic                 wgt_last;
  logic [ID_WIDTH-1:0]  pe_cnt;
  logic                 pe_last;
  logic [FL_WIDTH-1:0]  fl_cnt;
  logic                 fl_last;
  logic [CNT_WIDTH-1:0] pop_cnt;
  logic                 pop_last;
  logic [CNT_WIDTH-1:0] res_cnt;
  logic                 res_last;

  // Weight slot within the current PE.
  sa_wrap_cnt #(.W(CNT_WIDTH)) u_wgt_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (cnt_clr),
    .i_inc  (wgt_acc),
    .i_term (wgt_term),
    .o_cnt  (wgt_cnt),
    .o_last (wgt_last)
  );

  // PE currently being loaded; advances when its last slot is accepted.
  sa_wrap_cnt #(.W(ID_WIDTH)) u_pe_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (cnt_clr),
    .i_inc  (wgt_acc && wgt_last),
    .i_term (cfg_pe_m1_reg),
    .o_cnt  (pe_cnt),
    .o_last (pe_last)
  );

  // Chain drain time: one cycle per load-chain register.
  sa_wrap_cnt #(.W(FL_WIDTH)) u_flush_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (cnt_clr),
    .i_inc  (state_reg == ST_FLUSH),
    .i_term (FL_TERM),
    .o_cnt  (fl_cnt),
    .o_last (fl_last)
  );

  // Activations issued to column 0.
  sa_wrap_cnt #(.W(CNT_WIDTH)) u_pop_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (cnt_clr),
    .i_inc  (act_acc),
    .i_term (wgt_term),
    .o_cnt  (pop_cnt),
    .o_last (pop_last)
  );

  // Results returned from the tail. The terminal value is the full count
  // and the increment is gated at the terminal, so this one saturates
  // instead of wrapping: results may all arrive before RUN finishes.
  assign res_window = (state_reg == ST_RUN) || (state_reg == ST_WAIT);
  assign res_inc    = i_res_vld && res_window && !res_last;

  sa_wrap_cnt #(.W(CNT_WIDTH)) u_res_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (cnt_clr),
    .i_inc  (res_inc),
    .i_term (cfg_wgt_reg),
    .o_cnt  (res_cnt),
    .o_last (res_last)
  );

  // All results in hand, counting the one arriving this cycle.
  assign res_hit = res_last || (res_inc && (res_cnt == wgt_term));

  // The raw counts of these counters only matter through their last flags.
  logic unused_cnts;
  assign unused_cnts = ^{wgt_cnt, fl_cnt, pop_cnt};

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_acc) begin
          state_next = cfg_legal ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (wgt_acc && wgt_last && pe_last) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fl_last) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (act_acc && pop_last) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (res_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Registered datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg      <= 1'b0;
      cfg_pe_m1_reg <= '0;
      cfg_wgt_reg   <= '0;
      load_vld_reg  <= 1'b0;
      load_id_reg   <= '0;
      load_data_reg <= '0;
      pop_vld_reg   <= 1'b0;
      left_data_reg <= '0;
    end else begin
      busy_reg <= (state_next != ST_IDLE);

      // The low bits are enough: for cfg = 2**ID_WIDTH they are zero and
      // the subtraction wraps to the all-ones last id.
      if (start_acc) begin
        cfg_pe_m1_reg <= i_cfg_pe_cnt[ID_WIDTH-1:0] - ID_WIDTH'(1);
        cfg_wgt_reg   <= i_cfg_wgt_cnt;
      end

      load_vld_reg <= wgt_acc;
      if (wgt_acc) begin
        load_id_reg   <= pe_cnt;
        load_data_reg <= i_wgt_data;
      end

      pop_vld_reg <= act_acc;
      if (act_acc) begin
        left_data_reg <= i_act_data;
      end
    end
  end

  assign o_busy      = busy_reg;
  assign o_done      = (state_reg == ST_DONE);
  assign o_load_vld  = load_vld_reg;
  assign o_load_id   = load_id_reg;
  assign o_load_data = load_data_reg;
  assign o_pop_vld   = pop_vld_reg;
  assign o_left_data = left_data_reg;

endmodule : sa_load_sched

// File: tb/tb_sa_load_sched.sv
// ---------------------------------------------------------------------------
// tb_sa_load_sched
//   Scoreboard bench: the driver pushes the expected load beats, pop pulses
//   and done pulse (with the cycle each must appear in) into queues; a
//   monitor on the falling edge pops and compares whenever the DUT presents
//   one of those outputs.
// ---------------------------------------------------------------------------
module tb_sa_load_sched;

  localparam int NUM_PE = 4;
  localparam int ID_W   = 6;
  localparam int DW     = 8;
  localparam int WD     = 4;
  localparam int CW     = $clog2(WD) + 1;

  logic            clk;
  logic            rst;
  logic            i_start;
  logic [ID_W:0]   i_cfg_pe_cnt;
  logic [CW-1:0]   i_cfg_wgt_cnt;
  logic            o_busy;
  logic            o_done;
  logic            i_wgt_vld;
  logic [DW-1:0]   i_wgt_data;
  logic            o_wgt_rdy;
  logic            i_act_vld;
  logic [DW-1:0]   i_act_data;
  logic            o_act_rdy;
  logic            o_load_vld;
  logic [ID_W-1:0] o_load_id;
  logic [DW-1:0]   o_load_data;
  logic            o_pop_vld;
  logic [DW-1:0]   o_left_data;
  logic            i_res_vld;

  sa_load_sched #(
    .NUM_PE        (NUM_PE),
    .ID_WIDTH      (ID_W),
    .IN_DATA_WIDTH (DW),
    .WGT_DEPTH     (WD),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_cfg_pe_cnt  (i_cfg_pe_cnt),
    .i_cfg_wgt_cnt (i_cfg_wgt_cnt),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .i_wgt_vld     (i_wgt_vld),
    .i_wgt_data    (i_wgt_data),
    .o_wgt_rdy     (o_wgt_rdy),
    .i_act_vld     (i_act_vld),
    .i_act_data    (i_act_data),
    .o_act_rdy     (o_act_rdy),
    .o_load_vld    (o_load_vld),
    .o_load_id     (o_load_id),
    .o_load_data   (o_load_data),
    .o_pop_vld     (o_pop_vld),
    .o_left_data   (o_left_data),
    .i_res_vld     (i_res_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far; stable at the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t load_q[$];
  exp_t pop_q[$];
  int   done_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @cyc %0d", nm, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h @cyc %0d", nm, act, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  exp_t mon_e;
  int   mon_d;

  always @(negedge clk) begin
    if (rst) begin
      if (o_load_vld) begin
        if (load_q.size() == 0) begin
          chk("load_unexp", o_load_vld, 0);
        end else begin
          mon_e = load_q.pop_front();
          chk("load_cyc", cyc, mon_e.cyc);
          chk("load_id", 32'(o_load_id), 32'(mon_e.id));
          chk("load_data", 32'(o_load_data), 32'(mon_e.data));
        end
      end
      if (o_pop_vld) begin
        if (pop_q.size() == 0) begin
          chk("pop_unexp", o_pop_vld, 0);
        end else begin
          mon_e = pop_q.pop_front();
          chk("pop_cyc", cyc, mon_e.cyc);
          chk("left_data", 32'(o_left_data), 32'(mon_e.data));
        end
      end
      if (o_done) begin
        if (done_q.size() == 0) begin
          chk("done_unexp", o_done, 0);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_cyc", cyc, mon_d);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver / reference model
  //   Load beat k goes to PE k / wgt_cnt; it must appear on the load port
  //   in the cycle after acceptance. Flush lasts NUM_PE cycles. Done comes
  //   in the cycle after the final result pulse, or after the cycle that
  //   follows the last pop if that is later.
  // -------------------------------------------------------------------------
  task automatic run_job(input int pe, input int wg, input bit directed);
    int   tot;
    int   k;
    int   n;
    int   budget;
    int   res_sent;
    int   res_edge;
    int   pop_edge;
    int   done_edge;
    bit   v;
    bit   flip;
    logic [7:0] d;
    exp_t e;
    int   act_pat [6] = '{1, 0, 1, 0, 0, 1};

    tot = pe * wg;
    @(negedge clk);
    i_cfg_pe_cnt  = (ID_W + 1)'(pe);
    i_cfg_wgt_cnt = CW'(wg);
    i_start       = 1'b1;
    @(negedge clk);
    i_start       = 1'b0;
    // Config must already be latched; scramble the inputs.
    i_cfg_pe_cnt  = (ID_W + 1)'($urandom);
    i_cfg_wgt_cnt = CW'($urandom);
    chk("busy_rise", o_busy, 1);

    // LOAD
    k = 0;
    budget = 0;
    while (k < tot && budget < 2000) begin
      chk("wgt_rdy_load", o_wgt_rdy, 1);
      v = directed ? 1'b1 : ($urandom_range(0, 99) >= 30);
      d = directed ? 8'(8'h11 + k) : 8'($urandom);
      i_wgt_vld  = v;
      i_wgt_data = d;
      i_res_vld  = directed ? 1'b0 : ($urandom_range(0, 3) == 0);
      i_start    = (budget == 1);
      if (v && o_wgt_rdy) begin
        e.cyc  = cyc + 1;
        e.id   = 8'(k / wg);
        e.data = d;
        load_q.push_back(e);
        k++;
      end
      @(negedge clk);
      budget++;
    end
    i_wgt_vld = 1'b0;
    i_start   = 1'b0;
    i_res_vld = 1'b0;
    if (k < tot) chk("load_timeout", k, tot);
    chk("wgt_rdy_after", o_wgt_rdy, 0);

    // FLUSH (stray result pulses here must be ignored)
    n = 0;
    while (!o_act_rdy && n < 100) begin
      i_res_vld = directed ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    i_res_vld = 1'b0;
    chk("flush_len", n, NUM_PE);

    // RUN
    k = 0;
    budget = 0;
    res_sent = 0;
    res_edge = 0;
    pop_edge = 0;
    while (k < wg && budget < 2000) begin
      chk("act_rdy_run", o_act_rdy, 1);
      v = directed ? (act_pat[budget % 6] == 1) : ($urandom_range(0, 99) >= 40);
      d = directed ? 8'(k + 1) : 8'($urandom);
      i_act_vld  = v;
      i_act_data = d;
      i_res_vld  = 1'b0;
      if (wg >= 2 && res_sent == 0 && k >= 1) begin
        i_res_vld = 1'b1;
        res_sent  = 1;
        res_edge  = cyc + 1;
      end
      if (v && o_act_rdy) begin
        e.cyc  = cyc + 1;
        e.id   = 8'h00;
        e.data = d;
        pop_q.push_back(e);
        pop_edge = cyc + 1;
        k++;
      end
      @(negedge clk);
      budget++;
    end
    i_act_vld = 1'b0;
    i_res_vld = 1'b0;
    if (k < wg) chk("run_timeout", k, wg);
    chk("act_rdy_after", o_act_rdy, 0);

    // Remaining results
    flip = 1'b1;
    while (res_sent < wg) begin
      v = directed ? flip : 1'($urandom_range(0, 1));
      flip = ~flip;
      i_res_vld = v;
      if (v) begin
        res_sent++;
        res_edge = cyc + 1;
      end
      @(negedge clk);
    end
    i_res_vld = 1'b0;
    done_edge = (res_edge > pop_edge) ? res_edge : pop_edge + 1;
    done_q.push_back(done_edge);

    n = 0;
    while (cyc < done_edge && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_in_done", o_busy, 1);
    @(negedge clk);
    chk("busy_fall", o_busy, 0);
    chk("done_single", o_done, 0);
  endtask

  task automatic run_bad(input int pe, input int wg);
    @(negedge clk);
    i_cfg_pe_cnt  = (ID_W + 1)'(pe);
    i_cfg_wgt_cnt = CW'(wg);
    i_start       = 1'b1;
    done_q.push_back(cyc + 1);
    @(negedge clk);
    i_start = 1'b0;
    chk("bad_busy", o_busy, 1);
    chk("bad_no_rdy", o_wgt_rdy, 0);
    @(negedge clk);
    chk("bad_idle", o_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_wgt_rdy"}, o_wgt_rdy, 0);
    chk({tag, "_act_rdy"}, o_act_rdy, 0);
    chk({tag, "_load_vld"}, o_load_vld, 0);
    chk({tag, "_load_id"}, 32'(o_load_id), 0);
    chk({tag, "_load_data"}, 32'(o_load_data), 0);
    chk({tag, "_pop_vld"}, o_pop_vld, 0);
    chk({tag, "_left_data"}, 32'(o_left_data), 0);
  endtask

  task automatic reset_mid_load();
    exp_t e;
    @(negedge clk);
    i_cfg_pe_cnt  = (ID_W + 1)'(3);
    i_cfg_wgt_cnt = CW'(1);
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      chk("rst_wgt_rdy", o_wgt_rdy, 1);
      i_wgt_vld  = 1'b1;
      i_wgt_data = 8'(8'hA0 + b);
      e.cyc  = cyc + 1;
      e.id   = 8'(b);
      e.data = i_wgt_data;
      load_q.push_back(e);
      @(negedge clk);
    end
    i_wgt_vld = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_async");
    @(negedge clk);
    rst = 1'b1;
    chk("rst_load_q", load_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b0;
    i_start       = 1'b0;
    i_cfg_pe_cnt  = '0;
    i_cfg_wgt_cnt = '0;
    i_wgt_vld     = 1'b0;
    i_wgt_data    = '0;
    i_act_vld     = 1'b0;
    i_act_data    = '0;
    i_res_vld     = 1'b0;
    #3 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    run_job(2, 3, 1'b1);

    run_bad(2, 0);
    run_bad(0, 2);
    run_bad(NUM_PE + 1, 2);
    run_bad(2, WD + 1);

    reset_mid_load();
    run_job(2, 3, 1'b0);

    run_job(1, 1, 1'b0);
    run_job(NUM_PE, WD, 1'b0);
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(1, NUM_PE)), int'($urandom_range(1, WD)), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("end_load_q", load_q.size(), 0);
    chk("end_pop_q", pop_q.size(), 0);
    chk("end_done_q", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sa_load_sched
